// File: rtl/morse_rx_decoder.sv
// Morse receiver: samples a keyed line on each unit tick, classifies
// marks as dots/dashes and decodes letter patterns to indices A..Z.
module morse_rx_decoder #(
  parameter int DOT_MAX    = 2,
  parameter int MARK_MAX   = 6,
  parameter int GAP_LETTER = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_in,
  output logic [4:0] char_code,
  output logic       char_valid,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    ERR_WAIT
  } state_t;

  localparam logic [3:0] DOT_C  = 4'(DOT_MAX);
  localparam logic [3:0] MARK_C = 4'(MARK_MAX);
  localparam logic [3:0] GAP_C  = 4'(GAP_LETTER);

  state_t     state_q, state_d;
  logic       sync1_q, sync2_q;
  logic [3:0] mcnt_q, mcnt_d;
  logic [3:0] scnt_q, scnt_d;
  logic [3:0] pat_q, pat_d;
  logic [2:0] len_q, len_d;
  logic [4:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  logic [3:0] mcnt_inc, scnt_inc;
  logic       dash;
  logic [5:0] dec;

  // Pattern bits above len are always zero, so {len,pat} is unique.
  function automatic logic [5:0] decode(input logic [2:0] l,
                                        input logic [3:0] p);
    logic [5:0] r;
    r = 6'd0;
    case ({l, p})
      7'b001_0000: r = {1'b1, 5'd4};
      7'b001_0001: r = {1'b1, 5'd19};
      7'b010_0000: r = {1'b1, 5'd8};
      7'b010_0001: r = {1'b1, 5'd0};
      7'b010_0010: r = {1'b1, 5'd13};
      7'b010_0011: r = {1'b1, 5'd12};
      7'b011_0000: r = {1'b1, 5'd18};
      7'b011_0001: r = {1'b1, 5'd20};
      7'b011_0010: r = {1'b1, 5'd17};
      7'b011_0011: r = {1'b1, 5'd22};
      7'b011_0100: r = {1'b1, 5'd3};
      7'b011_0101: r = {1'b1, 5'd10};
      7'b011_0110: r = {1'b1, 5'd6};
      7'b011_0111: r = {1'b1, 5'd14};
      7'b100_0000: r = {1'b1, 5'd7};
      7'b100_0001: r = {1'b1, 5'd21};
      7'b100_0010: r = {1'b1, 5'd5};
      7'b100_0100: r = {1'b1, 5'd11};
      7'b100_0110: r = {1'b1, 5'd15};
      7'b100_0111: r = {1'b1, 5'd9};
      7'b100_1000: r = {1'b1, 5'd1};
      7'b100_1001: r = {1'b1, 5'd23};
      7'b100_1010: r = {1'b1, 5'd2};
      7'b100_1011: r = {1'b1, 5'd24};
      7'b100_1100: r = {1'b1, 5'd25};
      7'b100_1101: r = {1'b1, 5'd16};
      default:     r = 6'd0;
    endcase
    return r;
  endfunction

  assign mcnt_inc = (mcnt_q == 4'hf) ? 4'hf : mcnt_q + 4'd1;
  assign scnt_inc = (scnt_q == 4'hf) ? 4'hf : scnt_q + 4'd1;
  assign dash     = (mcnt_q > DOT_C);
  assign dec      = decode(len_q, pat_q);

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    scnt_d  = scnt_q;
    pat_d   = pat_q;
    len_d   = len_q;
    code_d  = code_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (sync2_q) begin
            state_d = MARK;
            mcnt_d  = 4'd1;
          end
        end
        MARK: begin
          if (sync2_q) begin
            mcnt_d = mcnt_inc;
            if (mcnt_inc > MARK_C) begin
              err_d   = 1'b1;
              pat_d   = 4'd0;
              len_d   = 3'd0;
              scnt_d  = 4'd0;
              state_d = ERR_WAIT;
            end
          end else if (len_q == 3'd4) begin
            // The falling edge already counts as the first gap tick.
            err_d   = 1'b1;
            pat_d   = 4'd0;
            len_d   = 3'd0;
            scnt_d  = 4'd1;
            state_d = ERR_WAIT;
          end else begin
            pat_d   = {pat_q[2:0], dash};
            len_d   = len_q + 3'd1;
            scnt_d  = 4'd1;
            state_d = SPACE;
          end
        end
        SPACE: begin
          if (sync2_q) begin
            state_d = MARK;
            mcnt_d  = 4'd1;
          end else begin
            scnt_d = scnt_inc;
            if (scnt_inc == GAP_C) begin
              if (dec[5]) begin
                code_d  = dec[4:0];
                valid_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
              pat_d   = 4'd0;
              len_d   = 3'd0;
              state_d = IDLE;
            end
          end
        end
        ERR_WAIT: begin
          if (sync2_q) begin
            scnt_d = 4'd0;
          end else begin
            scnt_d = scnt_inc;
            if (scnt_inc == GAP_C) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      mcnt_q  <= 4'd0;
      scnt_q  <= 4'd0;
      pat_q   <= 4'd0;
      len_q   <= 3'd0;
      code_q  <= 5'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      mcnt_q  <= mcnt_d;
      scnt_q  <= scnt_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign char_code  = code_q;
  assign char_valid = valid_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Directed bench for morse_rx_decoder: letters, errors, reset, tick gating.
module tb_morse_rx_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       key_in;
  logic [4:0] char_code;
  logic       char_valid;
  logic       err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  morse_rx_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .key_in    (key_in),
    .char_code (char_code),
    .char_valid(char_valid),
    .err       (err),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (char_valid || err) begin
      n_cmp++;
      if (char_valid && err) begin
        n_bad++;
        $display("FAIL both_pulses: char_valid=%b err=%b required not both",
                 char_valid, err);
      end
    end
  end

  // One unit: settle key through the synchronizer, then one tick.
  task automatic step(input logic k);
    key_in = k;
    repeat (3) @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(s[i] == "1");
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; tick = 1'b0; key_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_code", char_code, 0);
    chk("rst_valid", char_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_e;
    step(1);
    chk("e_busy_mark", busy, 1);
    send("00");
    chk("e_no_early", char_valid, 0);
    step(0);
    chk("e_valid", char_valid, 1);
    chk("e_code", char_code, 4);
    chk("e_busy_fall", busy, 0);
  endtask

  task automatic test_a_q;
    send("10111000");
    chk("a_valid", char_valid, 1);
    chk("a_code", char_code, 0);
    send("111011101011100");
    step(0);
    chk("q_valid", char_valid, 1);
    chk("q_code", char_code, 16);
  endtask

  task automatic test_five_dots;
    send("101010101");
    chk("five_busy", busy, 1);
    step(0);
    chk("five_err", err, 1);
    chk("five_novalid", char_valid, 0);
    step(0);
    chk("five_wait", busy, 1);
    step(0);
    chk("five_idle", busy, 0);
    chk("five_code_kept", char_code, 16);
  endtask

  task automatic test_long_mark;
    send("111111");
    chk("long_no_err6", err, 0);
    step(1);
    chk("long_err7", err, 1);
    chk("long_busy", busy, 1);
    send("000");
    chk("long_idle", busy, 0);
    send("111000");
    chk("t_valid", char_valid, 1);
    chk("t_code", char_code, 19);
  endtask

  task automatic test_illegal;
    send("1010111011100");
    step(0);
    chk("ill_err", err, 1);
    chk("ill_novalid", char_valid, 0);
    chk("ill_code_kept", char_code, 19);
    chk("ill_idle", busy, 0);
  endtask

  task automatic test_reset_mid;
    send("111010");
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #3;
    chk("mid_code", char_code, 0);
    chk("mid_valid", char_valid, 0);
    chk("mid_err", err, 0);
    chk("mid_busy0", busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    send("1000");
    chk("mid_e_valid", char_valid, 1);
    chk("mid_e_code", char_code, 4);
  endtask

  task automatic test_tick_low;
    step(1);
    for (int i = 0; i < 12; i++) begin
      key_in = i[0];
      @(posedge clk);
      #1;
    end
    key_in = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("tl_busy", busy, 1);
    chk("tl_novalid", char_valid, 0);
    send("000");
    chk("tl_valid", char_valid, 1);
    chk("tl_code", char_code, 4);
    repeat (40) @(posedge clk);
    #1;
    chk("idle_quiet", busy, 0);
  endtask

  initial begin
    test_reset;
    test_e;
    test_a_q;
    test_five_dots;
    test_long_mark;
    test_illegal;
    test_reset_mid;
    test_tick_low;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
